braille_dot_sequencer: RTL and testbench

- Downstream stage of the Brailliance top level. Consumes one braille cell pattern (one bit per dot) over a valid/ready handshake.
- Drives the cell's dot actuators in three phases:
  - energises raised dots one at a time, to limit peak current;
  - holds the full pattern for a fixed display time;
  - blanks all dots for a gap, then signals completion.

---
 rtl/braille_dot_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_braille_dot_sequencer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/braille_dot_sequencer.sv
// braille_dot_sequencer
//   Takes one braille cell pattern over a valid/ready handshake and drives the
//   dot actuators in three phases: each raised dot is energised alone in turn
//   (pickup, limits peak current), then the full pattern is held, then all
//   dots are blanked for a gap before completion is signalled.
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst        synchronous active-high reset
//   in_valid   in_dots carries a pattern
//   in_ready   block accepts a pattern this cycle (forced low during reset)
//   in_dots    bit i = dot i+1 raised
//   dot_out    registered actuator drive, bit i energises dot i+1
//   busy       a cell is being displayed
//   cell_done  one-cycle pulse when a cell finishes its gap
//
// Optional build macro: BRAILLE_SEQ_PREFETCH_EN adds a one-entry input buffer
// so the next pattern can be accepted while busy and started straight after
// the current gap, with no IDLE cycle in between.

module braille_dot_sequencer #(
  parameter int DOTS         = 6,
  parameter int PULSE_CYCLES = 16,
  parameter int HOLD_CYCLES  = 1024,
  parameter int GAP_CYCLES   = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DOTS-1:0] in_dots,
  output logic [DOTS-1:0] dot_out,
  output logic            busy,
  output logic            cell_done
);

  localparam int IW = $clog2(DOTS);
  localparam int PW = $clog2(PULSE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  // One phase counter shared by all states, sized for the longest phase.
  localparam int CW = (PW > HW) ? ((PW > GW) ? PW : GW) : ((HW > GW) ? HW : GW);

  typedef enum logic [1:0] {IDLE, PULSE, HOLD, GAP} state_t;

  state_t          state_q, state_d;
  logic [DOTS-1:0] pat_q, pat_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DOTS-1:0] dot_d;
  logic            done_d;

  logic            xfer;
  logic            gap_end;
  logic            start_go;
  logic [DOTS-1:0] start_pat;
  logic [DOTS-1:0] low_mask;
  logic [DOTS-1:0] higher;
  logic [IW-1:0]   start_idx;
  logic [IW-1:0]   next_idx;

  function automatic logic [IW-1:0] lowest_bit(input logic [DOTS-1:0] p);
    lowest_bit = '0;
    for (int i = DOTS - 1; i >= 0; i--) begin
      if (p[i]) lowest_bit = IW'(i);
    end
  endfunction

  assign xfer    = in_valid & in_ready;
  assign gap_end = (state_q == GAP) && (cnt_q == CW'(GAP_CYCLES - 1));
  assign busy    = (state_q != IDLE);

`ifdef BRAILLE_SEQ_PREFETCH_EN
  logic [DOTS-1:0] buf_q, buf_d;
  logic            buf_full_q, buf_full_d;
  logic            drain;

  assign in_ready = ~buf_full_q & ~rst;

  // A new cell starts either from the input directly (IDLE, or gap end with
  // nothing buffered) or from the buffer at gap end. Anything accepted that
  // does not start immediately is parked in the buffer.
  always_comb begin
    start_go   = 1'b0;
    start_pat  = in_dots;
    drain      = 1'b0;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    if (state_q == IDLE && xfer) begin
      start_go = 1'b1;
    end else if (gap_end && buf_full_q) begin
      start_go   = 1'b1;
      start_pat  = buf_q;
      drain      = 1'b1;
      buf_full_d = 1'b0;
    end else if (gap_end && xfer) begin
      start_go = 1'b1;
    end
    if (xfer && !(start_go && !drain)) begin
      buf_d      = in_dots;
      buf_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
    end
  end
`else
  assign in_ready  = (state_q == IDLE) & ~rst;
  assign start_go  = (state_q == IDLE) & xfer;
  assign start_pat = in_dots;
`endif

  // Bits of pat_q strictly above the current dot; the lowest of these is the
  // next dot to pulse, so clear bits are skipped without spending cycles.
  assign low_mask  = ((DOTS'(1) << idx_q) << 1) - DOTS'(1);
  assign higher    = pat_q & ~low_mask;
  assign next_idx  = lowest_bit(higher);
  assign start_idx = lowest_bit(start_pat);

  // Next-state logic. dot_out is registered, so its next value is computed
  // alongside the state it belongs to.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CW'(1);
    dot_d   = dot_out;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        dot_d = '0;
      end
      PULSE: begin
        if (cnt_q == CW'(PULSE_CYCLES - 1)) begin
          cnt_d = '0;
          if (higher != '0) begin
            idx_d = next_idx;
            dot_d = DOTS'(1) << next_idx;
          end else begin
            state_d = HOLD;
            dot_d   = pat_q;
          end
        end
      end
      HOLD: begin
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          state_d = GAP;
          cnt_d   = '0;
          dot_d   = '0;
        end
      end
      GAP: begin
        if (gap_end) begin
          state_d = IDLE;
          cnt_d   = '0;
          dot_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        dot_d   = '0;
      end
    endcase

    // A blank cell (space) skips pickup and goes straight to the hold phase.
    if (start_go) begin
      pat_d = start_pat;
      cnt_d = '0;
      if (start_pat != '0) begin
        state_d = PULSE;
        idx_d   = start_idx;
        dot_d   = DOTS'(1) << start_idx;
      end else begin
        state_d = HOLD;
        idx_d   = '0;
        dot_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      dot_out   <= '0;
      cell_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      dot_out   <= dot_d;
      cell_done <= done_d;
    end
  end

endmodule

// File: tb/tb_braille_dot_sequencer.sv
// tb_braille_dot_sequencer
//   Bench for braille_dot_sequencer (base build) with PULSE_CYCLES=4,
//   HOLD_CYCLES=10, GAP_CYCLES=3, DOTS=6. A reference model keeps the
//   expected per-cycle dot_out timeline of the cell on display as a queue.

module tb_braille_dot_sequencer;

  localparam int DOTS = 6;
  localparam int PC   = 4;
  localparam int HC   = 10;
  localparam int GC   = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [DOTS-1:0] in_dots;
  logic [DOTS-1:0] dot_out;
  logic            busy;
  logic            cell_done;

  braille_dot_sequencer #(
    .DOTS(DOTS), .PULSE_CYCLES(PC), .HOLD_CYCLES(HC), .GAP_CYCLES(GC)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_dots(in_dots), .dot_out(dot_out), .busy(busy), .cell_done(cell_done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: one queue entry per remaining busy cycle of the current cell.
  logic [DOTS-1:0] exp_q[$];
  logic            exp_done;

  logic [DOTS-1:0] obs_dot;
  logic            obs_busy;
  logic            obs_done;
  logic            obs_ready;

  typedef struct {
    logic [DOTS-1:0] pat;
    int              exp_busy;
    logic [DOTS-1:0] exp_first;
    logic [DOTS-1:0] exp_hold;
  } vec_t;

  vec_t vecs[6];

  // Expand a pattern into its display timeline: each raised dot alone for
  // PC cycles in ascending order, the full pattern for HC, blank for GC.
  function automatic void build_cell(input logic [DOTS-1:0] p);
    logic [DOTS-1:0] one;
    for (int i = 0; i < DOTS; i++) begin
      if (p[i]) begin
        one = '0;
        one[i] = 1'b1;
        for (int k = 0; k < PC; k++) exp_q.push_back(one);
      end
    end
    for (int k = 0; k < HC; k++) exp_q.push_back(p);
    for (int k = 0; k < GC; k++) exp_q.push_back('0);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Sample outputs mid-cycle and compare against the model's current cycle.
  task automatic checkOutput();
    logic            e_busy;
    logic [DOTS-1:0] e_dot;
    e_busy    = (exp_q.size() != 0);
    e_dot     = e_busy ? exp_q[0] : '0;
    obs_dot   = dot_out;
    obs_busy  = busy;
    obs_done  = cell_done;
    obs_ready = in_ready;
    check("dot_out",   {26'd0, dot_out}, {26'd0, e_dot});
    check("busy",      {31'd0, busy},      {31'd0, e_busy});
    check("cell_done", {31'd0, cell_done}, {31'd0, exp_done});
    check("in_ready",  {31'd0, in_ready},  {31'd0, (!e_busy && !rst)});
  endtask

  // Drive one cycle of inputs, check, then advance the model past the edge.
  task automatic applyStimulus(input logic r, input logic v, input logic [DOTS-1:0] d);
    logic was_busy;
    rst      = r;
    in_valid = v;
    in_dots  = d;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    if (r) begin
      exp_q.delete();
      exp_done = 1'b0;
    end else begin
      was_busy = (exp_q.size() != 0);
      exp_done = 1'b0;
      if (was_busy) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) exp_done = 1'b1;
      end else if (v) begin
        build_cell(d);
      end
    end
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busy_cnt;
    int done_cnt;
    logic done_seen;
    logic [DOTS-1:0] first_dot;
    logic [DOTS-1:0] hold_dot;
    logic [DOTS-1:0] ed;

    vecs[0] = '{6'b000101, 2*PC + HC + GC, 6'b000001, 6'b000101};
    vecs[1] = '{6'b000000, HC + GC,        6'b000000, 6'b000000};
    vecs[2] = '{6'b111111, 6*PC + HC + GC, 6'b000001, 6'b111111};
    vecs[3] = '{6'b100000, PC + HC + GC,   6'b100000, 6'b100000};
    vecs[4] = '{6'b010010, 2*PC + HC + GC, 6'b000010, 6'b010010};
    vecs[5] = '{6'b101010, 3*PC + HC + GC, 6'b000010, 6'b101010};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_dots  = '0;
    exp_q.delete();
    exp_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] reset and idle");
    applyStimulus(1'b1, 1'b0, '0);
    repeat (3) applyStimulus(1'b0, 1'b0, '0);

    $display("[TB] table of cell patterns");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b1, vecs[i].pat);
      busy_cnt  = 0;
      done_seen = 1'b0;
      first_dot = 'x;
      hold_dot  = 'x;
      for (int n = 0; n < 100; n++) begin
        applyStimulus(1'b0, 1'b0, $urandom);
        if (obs_busy) begin
          if (busy_cnt == 0) first_dot = obs_dot;
          if (busy_cnt == vecs[i].exp_busy - GC - 1) hold_dot = obs_dot;
          busy_cnt++;
        end
        if (obs_done) begin
          done_seen = 1'b1;
          break;
        end
      end
      check("vec_done_seen",  {31'd0, done_seen}, 32'd1);
      check("vec_busy_count", busy_cnt, vecs[i].exp_busy);
      check("vec_first_dot",  {26'd0, first_dot}, {26'd0, vecs[i].exp_first});
      check("vec_hold_dot",   {26'd0, hold_dot},  {26'd0, vecs[i].exp_hold});
    end

    $display("[TB] cycle-exact sequence for 000101");
    applyStimulus(1'b0, 1'b1, 6'b000101);
    for (int t = 1; t <= 22; t++) begin
      applyStimulus(1'b0, 1'b0, '0);
      if (t <= 4)       ed = 6'b000001;
      else if (t <= 8)  ed = 6'b000100;
      else if (t <= 18) ed = 6'b000101;
      else              ed = 6'b000000;
      check("seq_dot",   {26'd0, obs_dot}, {26'd0, ed});
      check("seq_ready", {31'd0, obs_ready}, (t == 22) ? 32'd1 : 32'd0);
      check("seq_done",  {31'd0, obs_done},  (t == 22) ? 32'd1 : 32'd0);
    end

    $display("[TB] reset during hold of 010010");
    applyStimulus(1'b0, 1'b1, 6'b010010);
    repeat (12) applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    check("rst_hold_dot",   {26'd0, obs_dot}, 32'h12);
    check("rst_ready_low",  {31'd0, obs_ready}, 32'd0);
    applyStimulus(1'b0, 1'b0, '0);
    check("post_rst_dot",   {26'd0, obs_dot}, 32'd0);
    check("post_rst_busy",  {31'd0, obs_busy}, 32'd0);
    check("post_rst_ready", {31'd0, obs_ready}, 32'd1);
    done_cnt = 0;
    for (int n = 0; n < 25; n++) begin
      applyStimulus(1'b0, 1'b0, '0);
      if (obs_done) done_cnt++;
    end
    check("post_rst_no_done", done_cnt, 0);

    $display("[TB] randomized traffic against model");
    for (int n = 0; n < 3000; n++) begin
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
                    DOTS'($urandom));
    end
    repeat (40) applyStimulus(1'b0, 1'b0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
